wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Writeback stage directly upstream of the register file; owns the file's single write port (wr_addr, wr_data, write_en).
- Merges two result sources:
  - the in-order pipeline, which always has priority and no backpressure;
  - the long-latency unit (loads, mul/div), which is queued in a small FIFO.
- Publishes a per-register busy scoreboard so decode can stall on pending long-latency writes.

Parameters:
DEPTH, 4, long-latency FIFO entries (power of two, >=2)
STARVE_LIMIT, 8, consecutive cycles a non-empty FIFO head may lose arbitration before pipe_stall asserts

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset; 0 = reset asserted
pipe_valid  input  1  pipeline result valid; no handshake, always consumed
pipe_addr  input  5  pipeline destination register
pipe_data  input  32  pipeline result
lat_valid  input  1  long-latency result offered
lat_ready  output  1  FIFO can accept; equals !full
lat_addr  input  5  long-latency destination register
lat_data  input  32  long-latency result
pipe_stall  output  1  registered; upstream holds pipe_valid=0 for every cycle this is 1
busy  output  32  busy[i]=1: write to register i is queued, not yet issued
wr_addr  output  5  register file write address (registered)
wr_data  output  32  register file write data (registered)
write_en  output  1  register file write enable (registered)
wb_conflict  output  1  registered one-cycle pulse: pipeline wrote a register marked busy

Behaviour:
- Reset (reset=0, async):
  - FIFO emptied; starve counter 0.
  - busy=0, write_en=0, wr_addr=0, wr_data=0, pipe_stall=0, wb_conflict=0.
  - lat_ready=1 from the first cycle after reset deasserts.
  - Reset mid-operation discards all queued entries; nothing is written after release.
- FIFO push: on lat_valid && lat_ready at a rising edge. An entry with lat_addr=0 is accepted and discarded: not stored, busy unchanged.
- lat_ready=0 when count==DEPTH, even if a pop occurs the same cycle; no full-cycle push/pop.
- Arbitration, each cycle, in priority order:
  - Pipe issue: pipe_valid && pipe_addr!=0 issues the pipe result.
  - FIFO pop: otherwise, a non-empty FIFO pops its head and issues it.
  - Idle: otherwise nothing issues.
  - pipe_valid with pipe_addr=0 counts as idle; the FIFO may pop.
- Issue latency:
  - The issued result is registered; write_en/wr_addr/wr_data are valid the cycle after the issue cycle.
  - write_en=0 on non-issue cycles; wr_addr/wr_data hold their last values.
  - Long-latency minimum: handshake at edge N, pop in cycle N+1, write_en=1 in cycle N+2.
- Starvation:
  - The starve counter increments each cycle the FIFO is non-empty and the pipe wins; it clears on any pop or when the FIFO is empty.
  - When the counter reaches STARVE_LIMIT, pipe_stall=1 for the next cycle.
  - In that cycle the FIFO pops (pipe_valid is guaranteed 0); the counter clears.
  - If pipe_valid=1 during pipe_stall (protocol violation), the pipe still wins.
- Scoreboard:
  - busy[a] is set at the edge of a push with a!=0.
  - busy[a] is cleared at the edge where that entry pops.
  - A same-edge push to the same address wins over the clear: busy stays 1.
  - Upstream guarantees at most one outstanding long-latency entry per register.
- Conflict: a pipe issue with busy[pipe_addr]=1 gives wb_conflict=1 next cycle. The write still happens; the busy bit is unchanged.
- Ordering: FIFO entries write in acceptance order; pointers wrap modulo DEPTH.

Test Plan:
- Reset, then lat push (addr 5, 0xDEADBEEF) at edge 1 with pipe idle -> busy[5]=1 after edge 1; write_en=1, wr_addr=5, wr_data=0xDEADBEEF in cycle 3; busy[5]=0 after edge 2.
- pipe_valid every cycle (addr 3, data 0x11) with lat push (addr 7, 0x22); STARVE_LIMIT=8 -> 8 pipe writes, then pipe_stall=1 for one cycle, then write_en with wr_addr=7, wr_data=0x22.
- Five back-to-back lat pushes, DEPTH=4, pipe busy -> lat_ready=0 after the 4th accept; the 5th is held until a pop; the writes emerge in order.
- lat push to addr 0 and pipe_valid to addr 0 -> write_en never asserts; busy stays 0; lat_ready stays 1.
- Three entries queued, reset pulled low mid-stream -> outputs and busy go to 0 immediately; no write_en after release.
- lat push to addr 9, then pipe write to addr 9 before the pop -> wb_conflict pulses once; pipe write issued; busy[9] stays 1 until the queued entry writes.

Source files
------------

// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback stage that owns the register file's single write port.
// The in-order pipeline always wins the port. Long-latency results (loads,
// mul/div) wait in a small FIFO and drain whenever the pipeline leaves a
// cycle free. A starvation counter forces a drain slot by raising pipe_stall.
// A per-register busy scoreboard tells decode which writes are still queued.
module wb_arbiter #(
  parameter int DEPTH        = 4,  // FIFO entries, power of two, >= 2
  parameter int STARVE_LIMIT = 8   // lost cycles tolerated before pipe_stall
) (
  input  logic        clk,
  input  logic        reset,       // asynchronous, active-low
  input  logic        pipe_valid,
  input  logic [4:0]  pipe_addr,
  input  logic [31:0] pipe_data,
  input  logic        lat_valid,
  output logic        lat_ready,
  input  logic [4:0]  lat_addr,
  input  logic [31:0] lat_data,
  output logic        pipe_stall,
  output logic [31:0] busy,
  output logic [4:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic        write_en,
  output logic        wb_conflict
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
  localparam logic [STV_W-1:0] STV_MAX    = STV_W'(STARVE_LIMIT);

  // One queued long-latency result.
  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } entry_t;

  // FIFO storage and bookkeeping
  entry_t             r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  // Arbitration / scoreboard state
  logic [STV_W-1:0]   r_starve;
  logic               r_pipe_stall;
  logic [31:0]        r_busy;

  // Registered write port
  logic               r_write_en;
  logic [4:0]         r_wr_addr;
  logic [31:0]        r_wr_data;
  logic               r_wb_conflict;

  // Per-cycle decisions
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_store;
  logic               w_pipe_issue;
  logic               w_pop;
  entry_t             w_head;
  logic [31:0]        w_busy_set;
  logic [31:0]        w_busy_clr;
  logic [31:0]        w_busy_next;
  logic [STV_W-1:0]   w_starve_next;
  logic [CNT_W-1:0]   w_count_next;

  // ---------------------------------------------------------------------------
  // Handshake and arbitration decisions.
  // lat_ready depends only on the registered count, so a pop in the same cycle
  // never re-opens a full FIFO; this keeps lat_ready free of any path from
  // pipe_valid.
  // ---------------------------------------------------------------------------
  assign w_full       = (r_count == FULL_COUNT);
  assign w_empty      = (r_count == '0);
  assign w_push       = lat_valid && !w_full;
  // Writes to r0 are architecturally void: accept them but never store them.
  assign w_store      = w_push && (lat_addr != 5'd0);
  // A pipeline result to r0 counts as an idle slot and lets the FIFO drain.
  assign w_pipe_issue = pipe_valid && (pipe_addr != 5'd0);
  assign w_pop        = !w_pipe_issue && !w_empty;
  assign w_head       = r_mem[r_rd_ptr];

  assign lat_ready    = !w_full;
  assign pipe_stall   = r_pipe_stall;
  assign busy         = r_busy;
  assign write_en     = r_write_en;
  assign wr_addr      = r_wr_addr;
  assign wr_data      = r_wr_data;
  assign wb_conflict  = r_wb_conflict;

  // Next scoreboard, next FIFO occupancy and next starvation count.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can leave
    // it unassigned, which is what would otherwise infer a latch.
    w_busy_set    = '0;
    w_busy_clr    = '0;
    w_count_next  = r_count;
    w_starve_next = '0;

    if (w_store) w_busy_set = 32'd1 << lat_addr;
    if (w_pop)   w_busy_clr = 32'd1 << w_head.addr;
    // Set is applied after clear so a same-edge push to the popping register
    // keeps its busy bit.
    w_busy_next = (r_busy & ~w_busy_clr) | w_busy_set;

    case ({w_store, w_pop})
      2'b10:   w_count_next = r_count + CNT_W'(1);
      2'b01:   w_count_next = r_count - CNT_W'(1);
      default: w_count_next = r_count;
    endcase

    // Count only cycles where a waiting head actually lost to the pipe. The
    // count saturates so a stall slot ignored by upstream re-asserts the stall.
    if (!w_empty && w_pipe_issue) begin
      if (r_starve == STV_MAX) w_starve_next = r_starve;
      else                     w_starve_next = r_starve + STV_W'(1);
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of block evaluation order.
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_store) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_next;
    end
  end

  // FIFO payload storage.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; an entry is only ever read after
    // the pointers say it was written, so clearing it would just cost logic.
    if (w_store) r_mem[r_wr_ptr] <= '{addr: lat_addr, data: lat_data};
  end

  // Scoreboard, starvation counter and the stall request derived from it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy       <= '0;
      r_starve     <= '0;
      r_pipe_stall <= 1'b0;
    end else begin
      r_busy       <= w_busy_next;
      r_starve     <= w_starve_next;
      r_pipe_stall <= (w_starve_next == STV_MAX);
    end
  end

  // Registered register-file write port and conflict flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_write_en    <= 1'b0;
      r_wr_addr     <= '0;
      r_wr_data     <= '0;
      r_wb_conflict <= 1'b0;
    end else begin
      r_write_en    <= w_pipe_issue || w_pop;
      // A pipe write to a register with a queued long-latency result is a
      // WAW hazard decode should have prevented; flag it, but still write.
      r_wb_conflict <= w_pipe_issue && r_busy[pipe_addr];
      if (w_pipe_issue) begin
        r_wr_addr <= pipe_addr;
        r_wr_data <= pipe_data;
      end else if (w_pop) begin
        r_wr_addr <= w_head.addr;
        r_wr_data <= w_head.data;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter: directed scenarios followed by a randomized run,
// all checked against a queue-based behavioural model of the writeback rules.
module tb_wb_arbiter;

  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 8;

  logic        clk;
  logic        reset;
  logic        pipe_valid;
  logic [4:0]  pipe_addr;
  logic [31:0] pipe_data;
  logic        lat_valid;
  logic        lat_ready;
  logic [4:0]  lat_addr;
  logic [31:0] lat_data;
  logic        pipe_stall;
  logic [31:0] busy;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        write_en;
  logic        wb_conflict;

  int n_checks = 0;
  int n_fail   = 0;

  wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .reset(reset),
    .pipe_valid(pipe_valid), .pipe_addr(pipe_addr), .pipe_data(pipe_data),
    .lat_valid(lat_valid), .lat_ready(lat_ready), .lat_addr(lat_addr),
    .lat_data(lat_data), .pipe_stall(pipe_stall), .busy(busy),
    .wr_addr(wr_addr), .wr_data(wr_data), .write_en(write_en),
    .wb_conflict(wb_conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_busy;
  int          m_starve;
  logic        e_we;
  logic [4:0]  e_addr;
  logic [31:0] e_data;
  logic        e_stall;
  logic        e_conf;

  task automatic model_reset();
    m_q.delete();
    m_busy   = '0;
    m_starve = 0;
    e_we     = 1'b0;
    e_addr   = '0;
    e_data   = '0;
    e_stall  = 1'b0;
    e_conf   = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model by one edge, then wait for
  // the edge and settle 1 time unit after it.
  task automatic cycle(input logic pv, input logic [4:0] pa, input logic [31:0] pd,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld);
    ent_t h;
    bit   ready, nonempty, pipe_wins;
    pipe_valid = pv; pipe_addr = pa; pipe_data = pd;
    lat_valid  = lv; lat_addr  = la; lat_data  = ld;
    ready     = (m_q.size() < DEPTH);
    nonempty  = (m_q.size() != 0);
    pipe_wins = pv && (pa != 5'd0);
    e_conf    = pipe_wins && m_busy[pa];
    if (pipe_wins) begin
      e_we = 1'b1; e_addr = pa; e_data = pd;
    end else if (nonempty) begin
      h = m_q.pop_front();
      e_we = 1'b1; e_addr = h.a; e_data = h.d;
      m_busy[h.a] = 1'b0;
    end else begin
      e_we = 1'b0;
    end
    if (lv && ready && la != 5'd0) begin
      h.a = la; h.d = ld;
      m_q.push_back(h);
      m_busy[la] = 1'b1;
    end
    if (nonempty && pipe_wins) m_starve = (m_starve >= STARVE_LIMIT) ? STARVE_LIMIT : m_starve + 1;
    else                       m_starve = 0;
    e_stall = (m_starve == STARVE_LIMIT);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0;
    pipe_valid = 1'b0; pipe_addr = '0; pipe_data = '0;
    lat_valid = 1'b0; lat_addr = '0; lat_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({write_en, wr_addr, wr_data, busy, pipe_stall, wb_conflict} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: we=%b addr=%0d data=%h busy=%h stall=%b conf=%b, required all 0",
               write_en, wr_addr, wr_data, busy, pipe_stall, wb_conflict);
    end
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (lat_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_lat_ready: got %b required 1", lat_ready);
    end
    n_checks++;
    if (write_en !== 1'b0 || busy !== 32'd0) begin
      n_fail++; $display("FAIL reset_idle: we=%b busy=%h required 0/0", write_en, busy);
    end
  endtask

  task automatic test_latency();
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF);
    n_checks++;
    if (busy !== 32'h0000_0020 || write_en !== 1'b0) begin
      n_fail++; $display("FAIL lat_after_push: busy=%h we=%b required 00000020/0", busy, write_en);
    end
    idle();
    n_checks++;
    if (write_en !== 1'b1 || wr_addr !== 5'd5 || wr_data !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL lat_write: we=%b addr=%0d data=%h required 1/5/deadbeef",
                         write_en, wr_addr, wr_data);
    end
    n_checks++;
    if (busy !== 32'd0) begin
      n_fail++; $display("FAIL lat_busy_clear: busy=%h required 0", busy);
    end
    idle();
    n_checks++;
    if (write_en !== 1'b0 || wr_addr !== 5'd5 || wr_data !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL lat_hold: we=%b addr=%0d data=%h required 0/5/deadbeef",
                         write_en, wr_addr, wr_data);
    end
  endtask

  task automatic test_starvation();
    int  n;
    bit  done;
    cycle(1'b1, 5'd3, 32'h11, 1'b1, 5'd7, 32'h22);
    n = 0;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (pipe_stall === 1'b1) begin
        done = 1;
      end else begin
        cycle(1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 32'd0);
        n++;
        n_checks++;
        if (write_en !== 1'b1 || wr_addr !== 5'd3 || wr_data !== 32'h11) begin
          n_fail++; $display("FAIL starve_pipe_write %0d: we=%b addr=%0d data=%h required 1/3/11",
                             n, write_en, wr_addr, wr_data);
        end
      end
    end
    n_checks++;
    if (!done || n != STARVE_LIMIT) begin
      n_fail++; $display("FAIL starve_count: stall_seen=%0d pipe_writes=%0d required 1/%0d",
                         done, n, STARVE_LIMIT);
    end
    idle();
    n_checks++;
    if (write_en !== 1'b1 || wr_addr !== 5'd7 || wr_data !== 32'h22 || pipe_stall !== 1'b0) begin
      n_fail++; $display("FAIL starve_drain: we=%b addr=%0d data=%h stall=%b required 1/7/22/0",
                         write_en, wr_addr, wr_data, pipe_stall);
    end
    n_checks++;
    if (busy !== 32'd0) begin
      n_fail++; $display("FAIL starve_busy: busy=%h required 0", busy);
    end
  endtask

  task automatic test_full();
    int         j;
    bit         rdy;
    logic [4:0] got_a[$];
    logic [31:0] got_d[$];
    j = 0;
    for (int c = 0; c < 60 && j < 5; c++) begin
      rdy = lat_ready;
      if (rdy && j == 4) begin
        n_checks++;
        if (got_a.size() == 0) begin
          n_fail++; $display("FAIL full_fifth_early: 5th accepted with %0d pops, required >=1", got_a.size());
        end
      end
      cycle(!pipe_stall, 5'd1, 32'h100 + 32'(c), 1'b1, 5'(10 + j), 32'hF00 + 32'(j));
      if (write_en && wr_addr >= 5'd10 && wr_addr <= 5'd14) begin
        got_a.push_back(wr_addr); got_d.push_back(wr_data);
      end
      if (rdy) begin
        j++;
        if (j == 4) begin
          n_checks++;
          if (lat_ready !== 1'b0) begin
            n_fail++; $display("FAIL full_ready: lat_ready=%b after 4th accept, required 0", lat_ready);
          end
        end
      end
    end
    n_checks++;
    if (j != 5) begin
      n_fail++; $display("FAIL full_timeout: accepted %0d of 5 entries", j);
    end
    repeat (10) begin
      idle();
      if (write_en && wr_addr >= 5'd10 && wr_addr <= 5'd14) begin
        got_a.push_back(wr_addr); got_d.push_back(wr_data);
      end
    end
    n_checks++;
    if (got_a.size() != 5) begin
      n_fail++; $display("FAIL full_count: %0d FIFO writes seen, required 5", got_a.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        n_checks++;
        if (got_a[k] !== 5'(10 + k) || got_d[k] !== 32'hF00 + 32'(k)) begin
          n_fail++; $display("FAIL full_order %0d: addr=%0d data=%h required %0d/%h",
                             k, got_a[k], got_d[k], 10 + k, 32'hF00 + 32'(k));
        end
      end
    end
  endtask

  task automatic test_addr_zero();
    repeat (4) begin
      cycle(1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h66);
      n_checks++;
      if (write_en !== 1'b0 || busy !== 32'd0 || lat_ready !== 1'b1) begin
        n_fail++; $display("FAIL addr_zero: we=%b busy=%h ready=%b required 0/0/1",
                           write_en, busy, lat_ready);
      end
    end
  endtask

  task automatic test_conflict();
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'hA9);
    cycle(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0);
    n_checks++;
    if (write_en !== 1'b1 || wr_addr !== 5'd9 || wr_data !== 32'h99 || wb_conflict !== 1'b1) begin
      n_fail++; $display("FAIL conflict_pulse: we=%b addr=%0d data=%h conf=%b required 1/9/99/1",
                         write_en, wr_addr, wr_data, wb_conflict);
    end
    n_checks++;
    if (busy !== 32'h0000_0200) begin
      n_fail++; $display("FAIL conflict_busy_kept: busy=%h required 00000200", busy);
    end
    // Queued entry pops while a new entry for the same register is pushed.
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'hB9);
    n_checks++;
    if (write_en !== 1'b1 || wr_data !== 32'hA9 || wb_conflict !== 1'b0 || busy !== 32'h0000_0200) begin
      n_fail++; $display("FAIL conflict_pop_push: we=%b data=%h conf=%b busy=%h required 1/a9/0/00000200",
                         write_en, wr_data, wb_conflict, busy);
    end
    idle();
    n_checks++;
    if (write_en !== 1'b1 || wr_data !== 32'hB9 || busy !== 32'd0) begin
      n_fail++; $display("FAIL conflict_second: we=%b data=%h busy=%h required 1/b9/0",
                         write_en, wr_data, busy);
    end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 3; i++) cycle(1'b1, 5'd2, 32'h200, 1'b1, 5'(20 + i), 32'hC0 + 32'(i));
    n_checks++;
    if (busy !== 32'h0070_0000) begin
      n_fail++; $display("FAIL midreset_setup: busy=%h required 00700000", busy);
    end
    pipe_valid = 1'b0; lat_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({write_en, wr_addr, wr_data, busy, pipe_stall, wb_conflict} !== '0) begin
      n_fail++; $display("FAIL midreset_async: we=%b addr=%0d data=%h busy=%h stall=%b conf=%b, required all 0",
                         write_en, wr_addr, wr_data, busy, pipe_stall, wb_conflict);
    end
    model_reset();
    @(posedge clk);
    #2 reset = 1'b1;
    repeat (6) begin
      idle();
      n_checks++;
      if (write_en !== 1'b0 || busy !== 32'd0 || lat_ready !== 1'b1) begin
        n_fail++; $display("FAIL midreset_after: we=%b busy=%h ready=%b required 0/0/1",
                           write_en, busy, lat_ready);
      end
    end
  endtask

  task automatic test_random();
    int          pct;
    logic        pv, lv;
    logic [4:0]  pa, la;
    for (int c = 0; c < 3000; c++) begin
      case ((c / 300) % 4)
        0:       pct = 90;
        1:       pct = 55;
        2:       pct = 25;
        default: pct = 97;
      endcase
      pv = e_stall ? 1'b0 : ($urandom_range(0, 99) < pct);
      pa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      lv = ($urandom_range(0, 99) < 50);
      la = 5'd0;
      if (lv && $urandom_range(0, 9) != 0) begin
        lv = 1'b0;
        for (int t = 0; t < 8 && !lv; t++) begin
          la = 5'($urandom_range(1, 31));
          if (!m_busy[la]) lv = 1'b1;
        end
      end
      cycle(pv, pa, $urandom(), lv, la, $urandom());
      n_checks++;
      if (write_en !== e_we || wr_addr !== e_addr || wr_data !== e_data) begin
        n_fail++; $display("FAIL rand_port cyc %0d: we=%b addr=%0d data=%h required %b/%0d/%h",
                           c, write_en, wr_addr, wr_data, e_we, e_addr, e_data);
      end
      n_checks++;
      if (busy !== m_busy) begin
        n_fail++; $display("FAIL rand_busy cyc %0d: busy=%h required %h", c, busy, m_busy);
      end
      n_checks++;
      if (pipe_stall !== e_stall || wb_conflict !== e_conf) begin
        n_fail++; $display("FAIL rand_flags cyc %0d: stall=%b conf=%b required %b/%b",
                           c, pipe_stall, wb_conflict, e_stall, e_conf);
      end
      n_checks++;
      if (lat_ready !== (m_q.size() < DEPTH)) begin
        n_fail++; $display("FAIL rand_ready cyc %0d: ready=%b required %b",
                           c, lat_ready, m_q.size() < DEPTH);
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_starvation();
    test_full();
    test_addr_zero();
    test_conflict();
    test_reset_midstream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
